// File: rtl/nf_lsu_pkg.sv
// Shared definitions for the MEM-stage load/store unit: size codes, FSM states,
// and the byte-lane align/extend helpers that any data-memory model can reuse.
package nf_lsu_pkg;

   localparam logic [1:0] LSU_B = 2'b00;
   localparam logic [1:0] LSU_H = 2'b01;
   localparam logic [1:0] LSU_W = 2'b10;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      REQ  = 2'b01,
      DONE = 2'b10
   } lsu_state_e;

   // Size code 2'b11 is handled as a word everywhere below.
   function automatic logic lsu_misaligned(input logic [1:0] size, input logic [1:0] k);
      case (size)
         LSU_B:   return 1'b0;
         LSU_H:   return k[0];
         default: return (k != 2'b00);
      endcase
   endfunction

   function automatic logic [3:0] lsu_be(input logic [1:0] size, input logic [1:0] k);
      case (size)
         LSU_B:   return 4'b0001 << k;
         LSU_H:   return 4'b0011 << k;
         default: return 4'b1111;
      endcase
   endfunction

   function automatic logic [31:0] lsu_wd(input logic [1:0] size, input logic [31:0] wd);
      case (size)
         LSU_B:   return {4{wd[7:0]}};
         LSU_H:   return {2{wd[15:0]}};
         default: return wd;
      endcase
   endfunction

   function automatic logic [31:0] lsu_ext(input logic [1:0] size, input logic uns,
                                           input logic [1:0] k, input logic [31:0] rd);
      logic [31:0] sh;
      sh = rd >> {k, 3'b000};
      case (size)
         LSU_B:   return uns ? {24'h000000, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
         LSU_H:   return uns ? {16'h0000, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
         default: return rd;
      endcase
   endfunction

endpackage

// File: rtl/nf_lsu_if.sv
// Data-bus interface between the load/store unit (master) and data memory (slave).
interface nf_lsu_if;
   logic [31:0] addr_dm;
   logic [31:0] wd_dm;
   logic [3:0]  be_dm;
   logic        we_dm;
   logic        req_dm;
   logic        bus_ack;
   logic [31:0] rd_dm;

   modport master (
      output addr_dm, wd_dm, be_dm, we_dm, req_dm,
      input  bus_ack, rd_dm
   );

   modport slave (
      input  addr_dm, wd_dm, be_dm, we_dm, req_dm,
      output bus_ack, rd_dm
   );
endinterface

// File: rtl/nf_lsu_align.sv
// Combinational byte-lane logic: store lane replication/enables and load extract/extend.
module nf_lsu_align
   import nf_lsu_pkg::*;
(
   input  logic [1:0]  st_size,
   input  logic [1:0]  st_addr_lo,
   input  logic [31:0] st_wd,
   output logic [3:0]  st_be,
   output logic [31:0] st_wd_lanes,
   output logic        st_misaligned,
   input  logic [1:0]  ld_size,
   input  logic        ld_uns,
   input  logic [1:0]  ld_addr_lo,
   input  logic [31:0] ld_rd,
   output logic [31:0] ld_data
);

   assign st_be         = lsu_be(st_size, st_addr_lo);
   assign st_wd_lanes   = lsu_wd(st_size, st_wd);
   assign st_misaligned = lsu_misaligned(st_size, st_addr_lo);
   assign ld_data       = lsu_ext(ld_size, ld_uns, ld_addr_lo, ld_rd);

endmodule

// File: rtl/nf_lsu.sv
// MEM-stage load/store unit: one outstanding bus transaction, pipeline stall via
// req_ack_dm, misalignment and bus-timeout detection.
module nf_lsu
   import nf_lsu_pkg::*;
#(
   parameter int TIMEOUT = 256
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        mem_req,
   input  logic        mem_we,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wd,
   input  logic [1:0]  mem_size,
   input  logic        mem_uns,
   output logic [31:0] mem_rd,
   output logic        req_ack_dm,
   output logic        lsu_err,
   nf_lsu_if.master    bus
);

   localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [TW-1:0] TO_LAST = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;

   lsu_state_e  state_q, state_d;
   logic [TW-1:0] timer_q, timer_d;
   logic        we_q, we_d;
   logic [1:0]  size_q, size_d;
   logic        uns_q, uns_d;
   logic [1:0]  k_q, k_d;
   logic [31:0] addr_dm_q, addr_dm_d;
   logic [31:0] wd_dm_q, wd_dm_d;
   logic [3:0]  be_dm_q, be_dm_d;
   logic        we_dm_q, we_dm_d;
   logic        req_dm_q, req_dm_d;
   logic [31:0] mem_rd_q, mem_rd_d;
   logic        lsu_err_q, lsu_err_d;

   logic [3:0]  st_be;
   logic [31:0] st_wd_lanes;
   logic        st_mis;
   logic [31:0] ld_data;
   logic        timeout_hit;

   nf_lsu_align u_align (
      .st_size      (mem_size),
      .st_addr_lo   (mem_addr[1:0]),
      .st_wd        (mem_wd),
      .st_be        (st_be),
      .st_wd_lanes  (st_wd_lanes),
      .st_misaligned(st_mis),
      .ld_size      (size_q),
      .ld_uns       (uns_q),
      .ld_addr_lo   (k_q),
      .ld_rd        (bus.rd_dm),
      .ld_data      (ld_data)
   );

   assign timeout_hit = (TIMEOUT != 0) && (timer_q == TO_LAST);

   // Next-state, latch and bus-output computation.
   always_comb begin
      state_d   = state_q;
      timer_d   = timer_q;
      we_d      = we_q;
      size_d    = size_q;
      uns_d     = uns_q;
      k_d       = k_q;
      addr_dm_d = addr_dm_q;
      wd_dm_d   = wd_dm_q;
      be_dm_d   = be_dm_q;
      we_dm_d   = we_dm_q;
      req_dm_d  = req_dm_q;
      mem_rd_d  = mem_rd_q;
      lsu_err_d = lsu_err_q;
      case (state_q)
         IDLE: begin
            if (mem_req) begin
               we_d      = mem_we;
               size_d    = mem_size;
               uns_d     = mem_uns;
               k_d       = mem_addr[1:0];
               addr_dm_d = {mem_addr[31:2], 2'b00};
               be_dm_d   = st_be;
               wd_dm_d   = st_wd_lanes;
               timer_d   = '0;
               if (st_mis) begin
                  state_d   = DONE;
                  lsu_err_d = 1'b1;
                  mem_rd_d  = 32'h0000_0000;
               end else begin
                  state_d  = REQ;
                  req_dm_d = 1'b1;
                  we_dm_d  = mem_we;
               end
            end else begin
               lsu_err_d = 1'b0;
            end
         end
         REQ: begin
            // A late ack landing in the timeout cycle still completes normally.
            if (bus.bus_ack) begin
               state_d   = DONE;
               req_dm_d  = 1'b0;
               we_dm_d   = 1'b0;
               lsu_err_d = 1'b0;
               mem_rd_d  = we_q ? 32'h0000_0000 : ld_data;
            end else if (timeout_hit) begin
               state_d   = DONE;
               req_dm_d  = 1'b0;
               we_dm_d   = 1'b0;
               lsu_err_d = 1'b1;
               mem_rd_d  = 32'h0000_0000;
            end else begin
               if (timer_q != {TW{1'b1}}) begin
                  timer_d = timer_q + TW'(1);
               end else begin
                  timer_d = timer_q;
               end
            end
         end
         DONE: begin
            state_d   = IDLE;
            lsu_err_d = 1'b0;
            mem_rd_d  = 32'h0000_0000;
         end
         default: begin
            state_d   = IDLE;
            req_dm_d  = 1'b0;
            we_dm_d   = 1'b0;
            lsu_err_d = 1'b0;
            mem_rd_d  = 32'h0000_0000;
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         timer_q   <= '0;
         we_q      <= 1'b0;
         size_q    <= LSU_W;
         uns_q     <= 1'b0;
         k_q       <= 2'b00;
         addr_dm_q <= 32'h0000_0000;
         wd_dm_q   <= 32'h0000_0000;
         be_dm_q   <= 4'b0000;
         we_dm_q   <= 1'b0;
         req_dm_q  <= 1'b0;
         mem_rd_q  <= 32'h0000_0000;
         lsu_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         timer_q   <= timer_d;
         we_q      <= we_d;
         size_q    <= size_d;
         uns_q     <= uns_d;
         k_q       <= k_d;
         addr_dm_q <= addr_dm_d;
         wd_dm_q   <= wd_dm_d;
         be_dm_q   <= be_dm_d;
         we_dm_q   <= we_dm_d;
         req_dm_q  <= req_dm_d;
         mem_rd_q  <= mem_rd_d;
         lsu_err_q <= lsu_err_d;
      end
   end

   // The stall must drop in the very cycle the MEM stage presents an op.
   assign req_ack_dm  = (state_q == DONE) || ((state_q == IDLE) && !mem_req);
   assign mem_rd      = mem_rd_q;
   assign lsu_err     = lsu_err_q;
   assign bus.addr_dm = addr_dm_q;
   assign bus.wd_dm   = wd_dm_q;
   assign bus.be_dm   = be_dm_q;
   assign bus.we_dm   = we_dm_q;
   assign bus.req_dm  = req_dm_q;

endmodule

// File: tb/tb_nf_lsu.sv
// Scoreboard bench for nf_lsu: driver issues ops, responder plays data memory,
// monitor compares completions against a byte-arithmetic reference model.
module tb_nf_lsu;
   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        mem_req, mem_we, mem_uns;
   logic [31:0] mem_addr, mem_wd;
   logic [1:0]  mem_size;
   logic [31:0] mem_rd;
   logic        req_ack_dm, lsu_err;
   bit          manual_bus = 1'b0;

   nf_lsu_if bus ();

   nf_lsu #(.TIMEOUT(TO)) dut (
      .clk       (clk),
      .reset     (reset),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wd    (mem_wd),
      .mem_size  (mem_size),
      .mem_uns   (mem_uns),
      .mem_rd    (mem_rd),
      .req_ack_dm(req_ack_dm),
      .lsu_err   (lsu_err),
      .bus       (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] rd;
      logic        err;
      bit          is_load;
   } res_t;

   typedef struct {
      logic [31:0] addr;
      logic        we;
      logic [3:0]  be;
      logic [31:0] wd;
      int          waits;
      logic [31:0] rd;
   } bus_t;

   res_t exp_q[$];
   bus_t bus_q[$];
   int   n_vec  = 0;
   int   n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: access width in bytes, lanes and extension by plain arithmetic.
   function automatic int m_nbytes(input logic [1:0] size);
      return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
   endfunction

   function automatic logic [3:0] m_be(input int nb, input logic [31:0] addr);
      int v;
      v = ((1 << nb) - 1) << (addr % 4);
      return v[3:0];
   endfunction

   function automatic logic [31:0] m_wd(input int nb, input logic [31:0] wd);
      logic [31:0] b, h;
      b = wd & 32'h0000_00FF;
      h = wd & 32'h0000_FFFF;
      if (nb == 1) return b * 32'h0101_0101;
      if (nb == 2) return h * 32'h0001_0001;
      return wd;
   endfunction

   function automatic logic [31:0] m_load(input int nb, input logic uns,
                                          input logic [31:0] addr, input logic [31:0] rd);
      logic [63:0] v, mask;
      mask = (64'd1 << (8 * nb)) - 64'd1;
      v = ({32'h0, rd} >> (8 * (addr % 4))) & mask;
      if (!uns && (((v >> (8 * nb - 1)) & 64'd1) == 64'd1)) v = v | ~mask;
      return v[31:0];
   endfunction

   // Driver: present one op at posedge+1, hold it until completion, scramble fields mid-flight.
   task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [1:0] size, input logic uns, input logic [31:0] rd,
                        input int waits);
      int   nb, stall, exp_stall;
      bit   done;
      res_t r;
      bus_t b;
      nb = m_nbytes(size);
      r.is_load = !we;
      if ((addr % nb) != 0) begin
         r.err = 1'b1; r.rd = 32'h0; exp_stall = 1;
      end else begin
         b.addr = addr & 32'hFFFF_FFFC; b.we = we; b.be = m_be(nb, addr);
         b.wd = m_wd(nb, wd); b.waits = waits; b.rd = rd;
         bus_q.push_back(b);
         if (waits >= TO) begin
            r.err = 1'b1; r.rd = 32'h0; exp_stall = 1 + TO;
         end else begin
            r.err = 1'b0; r.rd = m_load(nb, uns, addr, rd); exp_stall = 2 + waits;
         end
      end
      exp_q.push_back(r);
      mem_req = 1'b1; mem_we = we; mem_addr = addr; mem_wd = wd; mem_size = size; mem_uns = uns;
      stall = 0;
      done = 1'b0;
      for (int c = 0; c < 60 && !done; c++) begin
         @(negedge clk);
         if (req_ack_dm) begin
            done = 1'b1;
         end else begin
            stall++;
            if (stall >= 2) begin
               mem_we = $urandom; mem_addr = $urandom; mem_wd = $urandom;
               mem_size = 2'($urandom_range(0, 3)); mem_uns = $urandom;
            end
         end
      end
      if (!done) chk("completion_timeout", 32'h0, 32'h1);
      chk("stall_cycles", 32'(stall), 32'(exp_stall));
      @(posedge clk);
      #1;
      mem_req = 1'b0;
   endtask

   // Monitor: completions are popped from the scoreboard; otherwise no error/stall leakage.
   always @(negedge clk) begin
      if (reset === 1'b0) begin
         if (mem_req && req_ack_dm) begin
            if (exp_q.size() == 0) begin
               chk("spurious_done", 32'h1, 32'h0);
            end else begin
               res_t e;
               e = exp_q.pop_front();
               chk("lsu_err", 32'(lsu_err), 32'(e.err));
               if (e.is_load) chk("mem_rd", mem_rd, e.rd);
            end
         end else begin
            chk("err_outside_done", 32'(lsu_err), 32'h0);
            if (!mem_req) chk("ack_when_idle", 32'(req_ack_dm), 32'h1);
         end
      end
   end

   // Responder: data memory with a scripted wait count per transaction.
   initial begin
      bus.bus_ack = 1'b0;
      bus.rd_dm   = 32'h0;
      forever begin
         @(negedge clk);
         if (bus.req_dm === 1'b1 && !manual_bus) begin
            if (bus_q.size() == 0) begin
               chk("spurious_req", 32'h1, 32'h0);
            end else begin
               bus_t b;
               int   n;
               b = bus_q.pop_front();
               n = (b.waits >= TO) ? TO : b.waits + 1;
               for (int c = 0; c < n; c++) begin
                  if (c > 0) @(negedge clk);
                  chk("req_dm_held", 32'(bus.req_dm), 32'h1);
                  chk("addr_dm", bus.addr_dm, b.addr);
                  chk("we_dm", 32'(bus.we_dm), 32'(b.we));
                  chk("be_dm", 32'(bus.be_dm), 32'(b.be));
                  if (b.we) chk("wd_dm", bus.wd_dm, b.wd);
                  bus.bus_ack = (c == b.waits);
                  bus.rd_dm   = bus.bus_ack ? b.rd : $urandom;
               end
               @(negedge clk);
               bus.bus_ack = 1'b0;
               chk("req_dm_dropped", 32'(bus.req_dm), 32'h0);
            end
         end
      end
   end

   initial begin
      reset = 1'b1;
      mem_req = 1'b0; mem_we = 1'b0; mem_addr = 32'h0; mem_wd = 32'h0;
      mem_size = 2'b00; mem_uns = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_req_dm", 32'(bus.req_dm), 32'h0);
      chk("rst_we_dm", 32'(bus.we_dm), 32'h0);
      chk("rst_be_dm", 32'(bus.be_dm), 32'h0);
      chk("rst_addr_dm", bus.addr_dm, 32'h0);
      chk("rst_wd_dm", bus.wd_dm, 32'h0);
      chk("rst_mem_rd", mem_rd, 32'h0);
      chk("rst_lsu_err", 32'(lsu_err), 32'h0);
      chk("rst_req_ack", 32'(req_ack_dm), 32'h1);
      reset = 1'b0;
      @(posedge clk);
      #1;

      issue(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 32'hDEAD_BEEF, 0);
      issue(1'b1, 32'h13, 32'h0000_00A5, 2'b00, 1'b0, 32'h1234_5678, 3);
      issue(1'b0, 32'h2, 32'h0, 2'b01, 1'b0, 32'h8001_0000, 1);
      issue(1'b0, 32'h2, 32'h0, 2'b01, 1'b1, 32'h8001_0000, 0);
      issue(1'b0, 32'h5, 32'h0, 2'b10, 1'b0, 32'hFFFF_FFFF, 0);
      issue(1'b0, 32'h40, 32'h0, 2'b10, 1'b0, 32'hCAFE_F00D, 100);
      issue(1'b0, 32'h7, 32'h0, 2'b01, 1'b0, 32'h0, 0);
      issue(1'b0, 32'h3, 32'h0, 2'b00, 1'b0, 32'h80_123456, 2);
      issue(1'b1, 32'h22, 32'h1234_BEEF, 2'b01, 1'b0, 32'h0, 0);
      issue(1'b0, 32'h8, 32'h0, 2'b11, 1'b0, 32'h0BAD_F00D, 1);

      for (int i = 0; i < 300; i++) begin
         int g;
         issue(1'($urandom), $urandom & 32'h0000_0FFF, $urandom, 2'($urandom_range(0, 3)),
               1'($urandom), $urandom, $urandom_range(0, 5));
         g = $urandom_range(0, 2);
         repeat (g) begin
            @(posedge clk);
            #1;
         end
      end

      // Reset while a transaction waits on the bus; a stray ack afterwards must do nothing.
      manual_bus = 1'b1;
      mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h20; mem_size = 2'b10; mem_uns = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("pre_rst_req_dm", 32'(bus.req_dm), 32'h1);
      reset = 1'b1;
      mem_req = 1'b0;
      @(negedge clk);
      chk("post_rst_req_dm", 32'(bus.req_dm), 32'h0);
      chk("post_rst_req_ack", 32'(req_ack_dm), 32'h1);
      reset = 1'b0;
      bus.bus_ack = 1'b1;
      @(negedge clk);
      bus.bus_ack = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("stray_ack_req_ack", 32'(req_ack_dm), 32'h1);
         chk("stray_ack_err", 32'(lsu_err), 32'h0);
         chk("stray_ack_req_dm", 32'(bus.req_dm), 32'h0);
      end
      chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
      chk("bus_queue_drained", 32'(bus_q.size()), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
